// File: rtl/dataset_pkg.sv
// Shared state type, sizing helpers and lane-slice macro for the dataset memory.
// Lane k of a row occupies bits [k*len +: len].
`ifndef DATASET_PKG_SV
`define DATASET_PKG_SV

`define DATASET_LANE(row, k, len) row[(k)*(len) +: (len)]

package dataset_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Index width that never collapses to zero, so a one-entry range still gets a 1-bit select.
    function automatic int idx_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    function automatic int lanes_of(input int max_features);
        return max_features + 1;
    endfunction

    function automatic int data_width_of(input int length, input int max_features);
        return length * lanes_of(max_features);
    endfunction

endpackage

`endif

// File: rtl/dataset_lane_mux.sv
// Combinational lane selector: picks one LENGTH-bit lane out of a full row.
// An index past the last lane yields zero.
module dataset_lane_mux #(
    parameter int LENGTH    = 16,
    parameter int LANES     = 16,
    parameter int FEAT_BITS = 4
) (
    input  logic [LENGTH*LANES-1:0] row,
    input  logic [FEAT_BITS-1:0]    feat,
    output logic [LENGTH-1:0]       lane_data
);

    always_comb begin
        lane_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (32'(feat) == 32'(k)) begin
                lane_data = `DATASET_LANE(row, k, LENGTH);
            end
        end
    end

endmodule

// File: rtl/dataset_mem.sv
// Dataset row memory: masked writes, 1-cycle reads with lane select, self-timed clear
// after reset, high-water row count and an out-of-range error pulse.
module dataset_mem
    import dataset_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH       = 16,
    parameter int DEPTH        = 100,
    localparam int LANES       = lanes_of(MAX_FEATURES),
    localparam int DATA_WIDTH  = data_width_of(LENGTH, MAX_FEATURES),
    localparam int FEAT_BITS   = idx_width(LANES)
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [LANES-1:0]      wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [FEAT_BITS-1:0]  rd_feat,
    output logic [DATA_WIDTH-1:0] rd_row,
    output logic [LENGTH-1:0]     rd_lane,
    output logic                  rd_valid,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err_oob
);

    localparam int                  ROW_BITS    = idx_width(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ROW_BITS-1:0] LAST_ROW    = ROW_BITS'(DEPTH - 1);

    state_t                state;
    state_t                state_next;
    logic [ROW_BITS-1:0]   clr_ptr;
    logic [ROW_BITS-1:0]   clr_ptr_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  feat_oob;
    logic                  err_next;
    logic [ROW_BITS-1:0]   wr_idx;
    logic [ROW_BITS-1:0]   rd_idx;
    logic [ADDR_WIDTH:0]   wr_top;
    logic [DATA_WIDTH-1:0] merged_row;
    logic [DATA_WIDTH-1:0] read_row;
    logic [LENGTH-1:0]     read_lane;

    // State register; RST always restarts the clear sweep from row 0.
    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        busy         = 1'b0;
        case (state)
            CLEAR: begin
                busy         = 1'b1;
                clr_ptr_next = clr_ptr + ROW_BITS'(1);
                if (clr_ptr == LAST_ROW) begin
                    state_next   = READY;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next = READY;
            end
        endcase
        wr_ready = ~busy;
    end

    assign ready       = (state == READY);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIMIT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIMIT);
    assign wr_ok       = ready && wr_en && wr_in_range;
    assign rd_ok       = ready && rd_en;
    assign wr_idx      = wr_addr[ROW_BITS-1:0];
    assign rd_idx      = rd_addr[ROW_BITS-1:0];
    assign wr_top      = {1'b0, wr_addr} + {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Masked lanes take the new data, the rest keep the stored row.
    always_comb begin
        merged_row = mem[wr_idx];
        for (int k = 0; k < LANES; k++) begin
            if (wr_mask[k]) begin
                `DATASET_LANE(merged_row, k, LENGTH) = `DATASET_LANE(wr_data, k, LENGTH);
            end
        end
    end

    // Write-first: a read of the row being written sees the merged result.
    always_comb begin
        read_row = '0;
        if (rd_in_range) begin
            if (wr_ok && (wr_addr == rd_addr)) begin
                read_row = merged_row;
            end else begin
                read_row = mem[rd_idx];
            end
        end
    end

    dataset_lane_mux #(
        .LENGTH    (LENGTH),
        .LANES     (LANES),
        .FEAT_BITS (FEAT_BITS)
    ) u_lane_mux (
        .row       (read_row),
        .feat      (rd_feat),
        .lane_data (read_lane)
    );

    generate
        if (LANES < (1 << FEAT_BITS)) begin : g_feat_check
            assign feat_oob = (32'(rd_feat) >= 32'(LANES));
        end else begin : g_feat_full
            assign feat_oob = 1'b0;
        end
    endgenerate

    assign err_next = ready && ((wr_en && !wr_in_range) ||
                                (rd_en && (!rd_in_range || feat_oob)));

    // The clear sweep owns the array while busy; afterwards only the write port touches it.
    always_ff @(posedge clk) begin
        if (!RST) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_ok) begin
                mem[wr_idx] <= merged_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            rd_row   <= '0;
            rd_lane  <= '0;
            rd_valid <= 1'b0;
            count    <= '0;
            err_oob  <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            err_oob  <= err_next;
            if (rd_ok) begin
                rd_row  <= read_row;
                rd_lane <= read_lane;
            end
            if (wr_ok && (wr_top > count)) begin
                count <= wr_top;
            end
        end
    end

endmodule

// File: tb/tb_dataset_mem.sv
// Randomised bench for dataset_mem against a lane-array reference model,
// including clear timing, masked/write-first cases, out-of-range and mid-clear reset.
module tb_dataset_mem;

    localparam int ADDR_WIDTH   = 12;
    localparam int MAX_FEATURES = 15;
    localparam int LENGTH       = 16;
    localparam int DEPTH        = 100;
    localparam int LANES        = 16;
    localparam int DATA_WIDTH   = 256;
    localparam int FEAT_BITS    = 4;

    logic                  clk = 1'b0;
    logic                  RST;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [LANES-1:0]      wr_mask;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [FEAT_BITS-1:0]  rd_feat;
    logic [DATA_WIDTH-1:0] rd_row;
    logic [LENGTH-1:0]     rd_lane;
    logic                  rd_valid;
    logic                  busy;
    logic [ADDR_WIDTH:0]   count;
    logic                  err_oob;

    dataset_mem #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .MAX_FEATURES (MAX_FEATURES),
        .LENGTH       (LENGTH),
        .DEPTH        (DEPTH)
    ) dut (
        .clk      (clk),
        .RST      (RST),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_feat  (rd_feat),
        .rd_row   (rd_row),
        .rd_lane  (rd_lane),
        .rd_valid (rd_valid),
        .busy     (busy),
        .count    (count),
        .err_oob  (err_oob)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [LENGTH-1:0]     ref_mem [DEPTH][LANES];
    int                    ref_count;
    logic [DATA_WIDTH-1:0] exp_row;
    logic [LENGTH-1:0]     exp_lane;

    task automatic checkOutput(input string tag, input logic [DATA_WIDTH-1:0] actual,
                               input logic [DATA_WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [DATA_WIDTH-1:0] rowOf(input int a);
        logic [DATA_WIDTH-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*LENGTH +: LENGTH] = ref_mem[a][k];
        return r;
    endfunction

    task automatic resetModel();
        for (int a = 0; a < DEPTH; a++)
            for (int k = 0; k < LANES; k++) ref_mem[a][k] = '0;
        ref_count = 0;
        exp_row   = '0;
        exp_lane  = '0;
    endtask

    // One READY-state cycle: drive, update model (write first, then read), check next cycle.
    task automatic applyStimulus(input logic we, input int wa, input logic [LANES-1:0] wm,
                                 input logic [DATA_WIDTH-1:0] wd, input logic re,
                                 input int ra, input int rf);
        logic exp_err;
        wr_en   = we;
        wr_addr = wa[ADDR_WIDTH-1:0];
        wr_mask = wm;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra[ADDR_WIDTH-1:0];
        rd_feat = rf[FEAT_BITS-1:0];
        exp_err = 1'b0;
        if (we) begin
            if (wa < DEPTH) begin
                for (int k = 0; k < LANES; k++)
                    if (wm[k]) ref_mem[wa][k] = wd[k*LENGTH +: LENGTH];
                if (wa + 1 > ref_count) ref_count = wa + 1;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (re) begin
            if (ra < DEPTH) begin
                exp_row  = rowOf(ra);
                exp_lane = ref_mem[ra][rf];
            end else begin
                exp_row  = '0;
                exp_lane = '0;
                exp_err  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("rd_valid", rd_valid, re);
        checkOutput("err_oob", err_oob, exp_err);
        checkOutput("count", count, ref_count);
        checkOutput("rd_row", rd_row, exp_row);
        checkOutput("rd_lane", rd_lane, exp_lane);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, '0, '0, 1'b0, 0, 0);
    endtask

    // Counts busy cycles; when noisy, hammers both ports and checks they are ignored.
    task automatic waitClear(input bit noisy, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 300) begin
            if (noisy) begin
                checkOutput("busy_rd_valid", rd_valid, 1'b0);
                checkOutput("busy_err_oob", err_oob, 1'b0);
                checkOutput("busy_count", count, 0);
                checkOutput("busy_wr_ready", wr_ready, 1'b0);
                wr_en   = 1'b1;
                wr_addr = ADDR_WIDTH'($urandom_range(0, 120));
                wr_mask = '1;
                wr_data = {8{$urandom()}};
                rd_en   = 1'b1;
                rd_addr = ADDR_WIDTH'($urandom_range(0, 120));
            end
            cycles++;
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        logic [DATA_WIDTH-1:0] d;

        RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; rd_feat = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b1);
        checkOutput("rst_wr_ready", wr_ready, 1'b0);
        checkOutput("rst_rd_valid", rd_valid, 1'b0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_err_oob", err_oob, 1'b0);
        checkOutput("rst_rd_row", rd_row, 0);
        checkOutput("rst_rd_lane", rd_lane, 0);

        RST = 1'b0;
        waitClear(1'b0, cycles);
        checkOutput("clear_cycles", cycles, DEPTH);
        checkOutput("ready_busy", busy, 1'b0);
        checkOutput("ready_wr_ready", wr_ready, 1'b1);
        resetModel();

        $display("[TB] read of last row after clear");
        applyStimulus(1'b0, 0, '0, '0, 1'b1, 99, 0);

        $display("[TB] masked write");
        applyStimulus(1'b1, 5, 16'hFFFF, {16{16'hAAAA}}, 1'b0, 0, 0);
        applyStimulus(1'b1, 5, 16'h8001, {16{16'h1234}}, 1'b0, 0, 0);
        applyStimulus(1'b0, 0, '0, '0, 1'b1, 5, 15);
        checkOutput("masked_lane15", rd_lane, 16'h1234);
        applyStimulus(1'b0, 0, '0, '0, 1'b1, 5, 0);
        checkOutput("masked_lane0", rd_lane, 16'h1234);
        applyStimulus(1'b0, 0, '0, '0, 1'b1, 5, 7);
        checkOutput("masked_lane7", rd_lane, 16'hAAAA);
        checkOutput("masked_count", count, 6);

        $display("[TB] write-first");
        d = {8{$urandom()}};
        d[3*LENGTH +: LENGTH] = 16'hBEEF;
        applyStimulus(1'b1, 7, 16'h0008, d, 1'b1, 7, 3);
        checkOutput("wf_lane", rd_lane, 16'hBEEF);

        $display("[TB] out of range");
        applyStimulus(1'b1, 100, 16'hFFFF, {16{16'h5555}}, 1'b0, 0, 0);
        idle();
        applyStimulus(1'b0, 0, '0, '0, 1'b1, 4095, 2);
        idle();
        applyStimulus(1'b1, 4000, 16'h0001, '1, 1'b1, 100, 1);

        $display("[TB] streaming reads");
        for (int i = 0; i < 10; i++) begin
            d = '0;
            d[LENGTH-1:0] = LENGTH'(i);
            applyStimulus(1'b1, i, 16'h0001, d, 1'b0, 0, 0);
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 0, '0, '0, 1'b1, i, 0);
        end
        idle();

        $display("[TB] random traffic");
        for (int n = 0; n < 300; n++) begin
            logic we, re;
            int wa, ra, rf;
            logic [LANES-1:0] wm;
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 19) == 0) ? int'($urandom_range(DEPTH, 4095))
                                               : int'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(DEPTH, 4095))
                                               : int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) == 0) ra = wa;
            rf = int'($urandom_range(0, LANES - 1));
            wm = LANES'($urandom());
            for (int w = 0; w < DATA_WIDTH / 32; w++) d[w*32 +: 32] = $urandom();
            applyStimulus(we, wa, wm, d, re, ra, rf);
        end
        idle();

        $display("[TB] reset mid-clear");
        RST = 1'b1;
        @(posedge clk);
        #1;
        RST = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("midclear_busy", busy, 1'b1);
        RST = 1'b1;
        @(posedge clk);
        #1;
        RST = 1'b0;
        waitClear(1'b1, cycles);
        checkOutput("restart_cycles", cycles, DEPTH);
        checkOutput("restart_count", count, 0);
        checkOutput("restart_rd_row", rd_row, 0);
        resetModel();
        applyStimulus(1'b0, 0, '0, '0, 1'b1, 5, 15);
        applyStimulus(1'b0, 0, '0, '0, 1'b1, 7, 3);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
